// File: rtl/rv64i_data_mem_if.sv
// CPU-side data bus and console byte stream of the rv64i data memory.
interface rv64i_data_mem_if #(parameter int XLEN = 64);
   // The CPU raises memory_re and/or memory_we with address, size and data stable and
   // holds them until mem_ready pulses for one cycle; mem_in is valid only in that cycle.
   // A console byte moves on every rising edge where con_valid and con_ready are both high.
   logic            memory_re;
   logic            memory_we;
   logic [XLEN-1:0] io_in_addr;
   logic [XLEN-1:0] io_out_addr;
   logic [XLEN-1:0] mem_out;
   logic [1:0]      mem_size;
   logic [XLEN-1:0] mem_in;
   logic            mem_ready;
   logic            bus_err;
   logic            con_valid;
   logic [7:0]      con_data;
   logic            con_ready;

   modport slave (
      input  memory_re, memory_we, io_in_addr, io_out_addr, mem_out, mem_size, con_ready,
      output mem_in, mem_ready, bus_err, con_valid, con_data
   );

   modport master (
      output memory_re, memory_we, io_in_addr, io_out_addr, mem_out, mem_size, con_ready,
      input  mem_in, mem_ready, bus_err, con_valid, con_data
   );
endinterface

// File: rtl/rv64i_data_mem.sv
// Fixed-latency data memory: byte-lane RAM window, console FIFO at address 0, sticky bus error.
module rv64i_data_mem #(
   parameter int              XLEN      = 64,
   parameter int              RAM_WORDS = 256,
   parameter logic [XLEN-1:0] RAM_BASE  = 64'h1000,
   parameter int              LATENCY   = 2,
   parameter int              CON_DEPTH = 8
) (
   input  logic            clk,
   input  logic            rst,
   rv64i_data_mem_if.slave bus,
   output logic [1:0]      o_dbg_state
);

   localparam int              IW       = $clog2(RAM_WORDS);
   localparam int              PW       = $clog2(CON_DEPTH);
   localparam int              NB       = XLEN / 8;
   localparam logic [XLEN-1:0] RAM_END  = RAM_BASE + XLEN'(8 * RAM_WORDS);
   localparam logic [3:0]      CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2, S_STALL = 2'd3} state_t;

   state_t          r_state;
   logic [3:0]      r_cnt;
   logic [XLEN-1:0] r_addr;
   logic [XLEN-1:0] r_wdata;
   logic [1:0]      r_size;
   logic            r_re;
   logic            r_we;
   logic            r_mem_ready;
   logic [XLEN-1:0] r_mem_in;
   logic            r_bus_err;
   logic [XLEN-1:0] r_ram [RAM_WORDS];
   logic [7:0]      r_fifo [CON_DEPTH];
   logic [PW:0]     r_wp;
   logic [PW:0]     r_rp;

   logic [IW+2:0]   w_rel;
   logic [IW-1:0]   w_idx;
   logic [2:0]      w_off;
   logic            w_in_ram, w_is_con, w_misalign, w_both, w_err;
   logic            w_con_wr, w_full, w_empty, w_pop, w_stall, w_push, w_ram_we;
   logic [PW:0]     w_count;
   logic [XLEN-1:0] w_word, w_szmask, w_wsh, w_merge, w_rdata;
   logic [NB-1:0]   w_bmask, w_lanes;

   // RAM_BASE is word aligned, so the low bits of the offset from the base are the lane.
   assign w_rel    = r_addr[IW+2:0] - RAM_BASE[IW+2:0];
   assign w_idx    = w_rel[IW+2:3];
   assign w_off    = w_rel[2:0];
   assign w_in_ram = (r_addr >= RAM_BASE) && (r_addr < RAM_END);
   assign w_is_con = (r_addr == '0);
   assign w_both   = r_re && r_we;
   assign w_word   = r_ram[w_idx];
   assign w_wsh    = r_wdata << {w_off, 3'b000};
   assign w_lanes  = w_bmask << w_off;

   assign w_misalign = ((r_size == 2'd1) && w_off[0]) ||
                       ((r_size == 2'd2) && (w_off[1:0] != 2'd0)) ||
                       ((r_size == 2'd3) && (w_off != 3'd0));
   assign w_err      = w_both || w_misalign || !(w_in_ram || w_is_con);

   assign w_count  = r_wp - r_rp;
   assign w_full   = (w_count == (PW+1)'(CON_DEPTH));
   assign w_empty  = (r_wp == r_rp);
   assign w_pop    = !w_empty && bus.con_ready;
   assign w_con_wr = r_we && w_is_con;
   // A full FIFO that is being popped this same cycle can still take the push.
   assign w_stall  = w_con_wr && w_full && !w_pop;
   assign w_push   = (r_state == S_RESP) && w_con_wr && !w_stall;
   assign w_ram_we = (r_state == S_RESP) && r_we && w_in_ram && !w_misalign;

   always_comb begin
      w_szmask = '1;
      w_bmask  = '1;
      case (r_size)
         2'd0: begin w_szmask = XLEN'(8'hFF);         w_bmask = NB'(1);     end
         2'd1: begin w_szmask = XLEN'(16'hFFFF);      w_bmask = NB'(3);     end
         2'd2: begin w_szmask = XLEN'(32'hFFFF_FFFF); w_bmask = NB'(4'hF);  end
         default: begin w_szmask = '1;                w_bmask = '1;         end
      endcase
      for (int b = 0; b < NB; b++) begin
         w_merge[b*8 +: 8] = w_lanes[b] ? w_wsh[b*8 +: 8] : w_word[b*8 +: 8];
      end
      w_rdata = '0;
      if (r_re && !w_both) begin
         if (w_is_con)
            w_rdata = XLEN'({w_full, w_empty});
         else if (w_in_ram && !w_misalign)
            w_rdata = (w_word >> {w_off, 3'b000}) & w_szmask;
      end
   end

   always_ff @(posedge clk) begin
      if (w_ram_we) r_ram[w_idx] <= w_merge;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_size      <= '0;
         r_re        <= 1'b0;
         r_we        <= 1'b0;
         r_mem_ready <= 1'b0;
         r_mem_in    <= '0;
         r_bus_err   <= 1'b0;
         r_wp        <= '0;
         r_rp        <= '0;
         for (int i = 0; i < CON_DEPTH; i++) r_fifo[i] <= '0;
      end else begin
         r_mem_ready <= 1'b0;
         r_mem_in    <= '0;
         if (w_pop) r_rp <= r_rp + 1'b1;
         if (w_push) begin
            r_fifo[r_wp[PW-1:0]] <= r_wdata[7:0];
            r_wp                 <= r_wp + 1'b1;
         end
         case (r_state)
            S_IDLE: begin
               // The request is still held during the ready pulse; skip that cycle.
               if ((bus.memory_re || bus.memory_we) && !r_mem_ready) begin
                  r_re    <= bus.memory_re;
                  r_we    <= bus.memory_we;
                  r_addr  <= bus.memory_we ? bus.io_out_addr : bus.io_in_addr;
                  r_size  <= bus.mem_size;
                  r_wdata <= bus.mem_out;
                  r_cnt   <= CNT_INIT;
                  r_state <= (LATENCY == 1) ? S_RESP : S_WAIT;
               end
            end
            S_WAIT: begin
               if (r_cnt == 4'd0) r_state <= S_RESP;
               else               r_cnt   <= r_cnt - 4'd1;
            end
            S_RESP: begin
               if (w_stall) begin
                  r_state <= S_STALL;
               end else begin
                  r_mem_ready <= 1'b1;
                  r_mem_in    <= w_rdata;
                  if (w_err) r_bus_err <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            S_STALL: begin
               if (!w_full || w_pop) r_state <= S_RESP;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.mem_ready = r_mem_ready;
   assign bus.mem_in    = r_mem_in;
   assign bus.bus_err   = r_bus_err;
   assign bus.con_valid = !w_empty;
   assign bus.con_data  = r_fifo[r_rp[PW-1:0]];
   assign o_dbg_state   = r_state;

endmodule

// File: doc/rv64i_data_mem.md
RV64I_DATA_MEM -- requirements
Module: rv64i_data_mem

Interface
REQ-001 SHALL have parameter XLEN, default 64, data path width.
REQ-002 SHALL have parameter RAM_WORDS, default 256, number of XLEN-bit RAM words.
REQ-003 SHALL have parameter RAM_BASE, default 64'h1000, byte address of RAM word 0.
REQ-004 SHALL have parameter LATENCY, default 2, range 1-15, cycles from request accept to mem_ready.
REQ-005 SHALL have parameter CON_DEPTH, default 8, power of 2, console FIFO entries.
REQ-006 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-007 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port memory_re, input, 1, read request, held until mem_ready.
REQ-009 SHALL have port io_in_addr, input, XLEN, read byte address.
REQ-010 SHALL have port mem_in, output, XLEN, read data, valid only while mem_ready is high.
REQ-011 SHALL have port memory_we, input, 1, write request, held until mem_ready.
REQ-012 SHALL have port io_out_addr, input, XLEN, write byte address.
REQ-013 SHALL have port mem_out, input, XLEN, write data, right-aligned.
REQ-014 SHALL have port mem_size, input, 2, access size: 0 byte, 1 half, 2 word, 3 double.
REQ-015 SHALL have port mem_ready, output, 1, one-cycle completion pulse.
REQ-016 SHALL have port bus_err, output, 1, sticky error flag.
REQ-017 SHALL have ports con_valid (output, 1), con_data (output, 8) and con_ready (input, 1), forming the console stream.

Function
REQ-018 SHALL implement FSM states IDLE, WAIT, RESP and STALL.
REQ-019 IDLE SHALL accept a request when memory_re or memory_we is high, latching address, size and data, then go to WAIT, or to RESP directly if LATENCY=1.
REQ-020 WAIT SHALL count LATENCY-1 cycles and then go to RESP, so mem_ready asserts exactly LATENCY cycles after the accept edge.
REQ-021 RESP SHALL assert mem_ready for one cycle, commit any write in that cycle, and return to IDLE.
REQ-022 A new request SHALL NOT be accepted in the cycle mem_ready is high; the earliest next accept is the following cycle.
REQ-023 If memory_re and memory_we are both high at accept, the block SHALL perform the write, return mem_in=0 and set bus_err.
REQ-024 Address map: 0x0 write SHALL push mem_out[7:0] to the console FIFO.
REQ-025 Address map: 0x0 read SHALL return {zeros, full, empty}.
REQ-026 Address map: RAM_BASE through RAM_BASE+8*RAM_WORDS-1 SHALL be RAM.
REQ-027 Address map: all other addresses SHALL ignore writes, return 0 on reads and set bus_err.
REQ-028 RAM word index SHALL be (addr-RAM_BASE)>>3; lane offset SHALL be addr[2:0].
REQ-029 A write SHALL update only the 1/2/4/8 bytes starting at the lane offset, taken from the low bytes of mem_out.
REQ-030 Read data SHALL be the addressed bytes shifted to bit 0 and zero-extended; the CPU performs sign extension.
REQ-031 Misaligned accesses (half with addr[0]=1; word with addr[1:0]!=0; double with addr[2:0]!=0) SHALL perform no write, return 0, set bus_err and still complete with mem_ready.
REQ-032 A console write with the FIFO full SHALL go to STALL instead of RESP, keeping mem_ready low until an entry is freed, then go to RESP and push.
REQ-033 con_valid SHALL equal FIFO not-empty, and con_data SHALL be the head entry.
REQ-034 A pop SHALL occur when con_valid and con_ready are both high.
REQ-035 A simultaneous push and pop SHALL keep the occupancy count unchanged.
REQ-036 FIFO pointers SHALL wrap modulo CON_DEPTH; occupancy SHALL span 0 to CON_DEPTH.
REQ-037 bus_err SHALL clear only on reset.

Reset
REQ-038 While rst is low, the block SHALL force the FSM to IDLE and set mem_ready=0, mem_in=0, bus_err=0, con_valid=0, con_data=0, FIFO pointers=0 and the latency counter=0.
REQ-039 Reset SHALL NOT clear RAM contents; RAM is undefined until written.
REQ-040 Reset asserted mid-transaction SHALL abort it with no write committed and no mem_ready.

Verification
REQ-041 LATENCY=2: sd 0x0F0F07F0_0F0F07F0 to 0x1000, then ld 0x1000 -> each mem_ready 2 cycles after accept; mem_in=64'h0F0F07F0_0F0F07F0.
REQ-042 sb 0xAB to 0x1003 over the REQ-041 data, then lw 0x1000 -> mem_in=64'h0000_0000_AB0F_07F0.
REQ-043 con_ready=0: nine sb writes to 0x0 -> eight complete; the ninth holds mem_ready low; raising con_ready for one cycle -> ninth completes; bytes emerge in order.
REQ-044 sh to 0x1001 and ld from 0x8 -> both complete; mem_in=0; bus_err=1; RAM unchanged.
REQ-045 rst driven low during WAIT of a write to 0x1010 -> no mem_ready; after release, ld 0x1010 returns the prior value; all outputs read their reset values.
REQ-046 memory_re and memory_we high together to 0x1008 -> write committed; mem_in=0; bus_err=1.
